// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared constants and helpers for the UART receive/transmit blocks.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_TO_CHARS   = 4;
    localparam int UART_TO_BITS    = UART_TO_CHARS * UART_FRAME_BITS;

    // A zero divider would stall the bit clock forever, so it behaves as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// Module   : uart_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with occupancy output.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = UART_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DW-1:0]           wr_data,
    input  logic                    rd_en,
    output logic [DW-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (wr_en) r_wptr <= r_wptr + c_ptr_one;
            if (rd_en) r_rptr <= r_rptr + c_ptr_one;
        end
    end

    // Storage is deliberately left without reset; head is meaningless while empty.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rptr[AW-1:0]];
    assign level   = r_wptr - r_rptr;
    assign empty   = (r_wptr == r_rptr);
    assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// Module   : uart_rx_fifo
// Brief    : UART receive buffer with overrun flag, level and idle-timeout interrupts.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TO_BITS = UART_TO_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             cfg_div,
    input  logic [$clog2(DEPTH):0]  cfg_thresh,
    input  logic                    cfg_flush,
    input  logic                    clr_ovr,
    input  logic                    rx_valid,
    input  logic [UART_DATA_W-1:0]  rx_data,
    input  logic                    rd_en,
    output logic [UART_DATA_W-1:0]  rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overrun,
    output logic                    irq_thresh,
    output logic                    irq_timeout
);

    localparam int BW = $clog2(TO_BITS + 1);
    localparam logic [BW-1:0] c_to_bits = BW'(TO_BITS);
    localparam logic [BW-1:0] c_bit_one = BW'(1);

    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic          w_tclr;
    logic [15:0]   w_div_eff;
    logic [15:0]   r_pre;
    logic [BW-1:0] r_bits;
    logic          r_overrun;
    logic          r_irq_to;

    // A full FIFO can still accept a byte when the head leaves in the same cycle.
    assign w_pop  = rd_en & ~empty & ~cfg_flush;
    assign w_push = rx_valid & (~full | w_pop) & ~cfg_flush;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (cfg_flush),
        .wr_en   (w_push),
        .wr_data (rx_data),
        .rd_en   (w_pop),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (rx_valid & full & ~w_pop & ~cfg_flush) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_div_eff = eff_div(cfg_div);
    assign w_tick    = (r_pre >= (w_div_eff - 16'd1));
    assign w_tclr    = w_push | w_pop | cfg_flush | empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre  <= '0;
            r_bits <= '0;
        end else if (w_tclr) begin
            r_pre  <= '0;
            r_bits <= '0;
        end else if (w_tick) begin
            r_pre  <= '0;
            if (r_bits != c_to_bits) r_bits <= r_bits + c_bit_one;
        end else begin
            r_pre  <= r_pre + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_to <= 1'b0;
        end else if (w_push | w_pop | cfg_flush) begin
            r_irq_to <= 1'b0;
        end else if ((r_bits == c_to_bits) && !empty) begin
            r_irq_to <= 1'b1;
        end
    end

    assign overrun     = r_overrun;
    assign irq_timeout = r_irq_to;
    assign irq_thresh  = (cfg_thresh != '0) && (level >= cfg_thresh);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo with a read-data scoreboard.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_div = 16'd868;
    logic [4:0]  cfg_thresh = 5'd0;
    logic        cfg_flush = 1'b0;
    logic        clr_ovr = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        overrun;
    logic        irq_thresh;
    logic        irq_timeout;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .TO_BITS(40)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_div     (cfg_div),
        .cfg_thresh  (cfg_thresh),
        .cfg_flush   (cfg_flush),
        .clr_ovr     (clr_ovr),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overrun     (overrun),
        .irq_thresh  (irq_thresh),
        .irq_timeout (irq_timeout)
    );

    // Scoreboard monitor: every accepted pop must present the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rd_en && !empty && !cfg_flush) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got %02h, queue empty", rd_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        bad++;
                        $display("FAIL pop_data: got %02h want %02h", rd_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit accept);
        rx_valid = 1'b1;
        rx_data  = d;
        if (accept) exp_q.push_back(d);
        cyc(1);
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic flush_all();
        cfg_flush = 1'b1;
        exp_q.delete();
        cyc(1);
        cfg_flush = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overrun", overrun, 0);
        check("rst_irq_thresh", irq_thresh, 0);
        check("rst_irq_timeout", irq_timeout, 0);

        // 1: three bytes in order
        push_byte(8'hA5, 1);
        push_byte(8'h3C, 1);
        push_byte(8'h7E, 1);
        check("t1_level", level, 3);
        check("t1_head", rd_data, 8'hA5);
        repeat (3) pop_one();
        check("t1_empty", empty, 1);

        // 2: overfill by one, then drain
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
        check("t2_full", full, 1);
        check("t2_level", level, 16);
        check("t2_ovr_pre", overrun, 0);
        push_byte(8'h10, 0);
        check("t2_overrun", overrun, 1);
        check("t2_level_kept", level, 16);
        repeat (16) pop_one();
        check("t2_empty", empty, 1);
        clr_ovr = 1'b1;
        cyc(1);
        clr_ovr = 1'b0;
        check("t2_clr_ovr", overrun, 0);

        // 3: push and pop together while full
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1);
        check("t3_full", full, 1);
        rd_en = 1'b1;
        push_byte(8'h55, 1);
        rd_en = 1'b0;
        check("t3_overrun", overrun, 0);
        check("t3_level", level, 16);
        repeat (16) pop_one();
        check("t3_empty", empty, 1);

        // 4: threshold interrupt
        cfg_thresh = 5'd4;
        push_byte(8'h01, 1);
        push_byte(8'h02, 1);
        push_byte(8'h03, 1);
        check("t4_below", irq_thresh, 0);
        push_byte(8'h04, 1);
        check("t4_at", irq_thresh, 1);
        pop_one();
        check("t4_after_pop", irq_thresh, 0);
        cfg_thresh = 5'd0;
        check("t4_disabled", irq_thresh, 0);
        repeat (3) pop_one();

        // 5: character timeout with cfg_div=868
        cfg_div = 16'd868;
        push_byte(8'hC3, 1);
        cyc(40 * 868 - 2);
        check("t5_early", irq_timeout, 0);
        cyc(4);
        check("t5_fired", irq_timeout, 1);
        pop_one();
        check("t5_pop_clears", irq_timeout, 0);
        check("t5_empty", empty, 1);
        cyc(40 * 868 + 20);
        check("t5_empty_no_to", irq_timeout, 0);

        // cfg_div of zero behaves as one
        cfg_div = 16'd0;
        push_byte(8'hE1, 1);
        cyc(38);
        check("div0_early", irq_timeout, 0);
        cyc(4);
        check("div0_fired", irq_timeout, 1);

        // 6: flush beats a same-cycle rx byte, clears timeout
        for (int i = 0; i < 4; i++) push_byte(8'h80 + 8'(i), 1);
        check("t6_level5", level, 5);
        cfg_flush = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h99;
        exp_q.delete();
        cyc(1);
        cfg_flush = 1'b0;
        rx_valid  = 1'b0;
        check("t6_level", level, 0);
        check("t6_empty", empty, 1);
        check("t6_irq_to", irq_timeout, 0);
        check("t6_overrun", overrun, 0);

        // async reset in mid-cycle discards contents
        cfg_div = 16'd868;
        push_byte(8'h11, 1);
        push_byte(8'h22, 1);
        #2 rst = 1'b1;
        #2;
        exp_q.delete();
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        push_byte(8'h5A, 1);
        check("arst_head", rd_data, 8'h5A);
        pop_one();

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
